// File: rtl/trk_pkg.sv
// rtl/trk_pkg.sv - shared record type and widths for the data-memory write tracker
package trk_pkg;

    localparam int TRK_ADDR_W = 15;
    localparam int TRK_DATA_W = 16;
    localparam int TRK_TS_W   = 32;

    // One captured write: timestamp of the capture cycle, Hack RAM address, data word
    typedef struct packed {
        logic [TRK_TS_W-1:0]   ts;
        logic [TRK_ADDR_W-1:0] addr;
        logic [TRK_DATA_W-1:0] data;
    } trk_entry_t;

    localparam int TRK_ENTRY_W = $bits(trk_entry_t);

endpackage

// File: rtl/trk_fifo.sv
// rtl/trk_fifo.sv - synchronous FIFO of trk_entry_t records with wrap-bit pointers
module trk_fifo
    import trk_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  trk_entry_t               i_entry,
    input  logic                     i_pop,
    output trk_entry_t               o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    trk_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    // Pointers carry one extra wrap bit, so equal low bits mean full when the MSBs differ
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees the head slot in the same edge, so a full FIFO can still take a push then
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Pointer update; reset flushes everything held
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/dmem_wr_tracker.sv
// rtl/dmem_wr_tracker.sv - timestamps Hack data-memory writes and streams them to a log sink
module dmem_wr_tracker
    import trk_pkg::*;
#(
    parameter int ADDR_W = TRK_ADDR_W,
    parameter int DATA_W = TRK_DATA_W,
    parameter int DEPTH  = 16,
    parameter int TS_W   = TRK_TS_W,
    parameter int DROP_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic                   WrEn,
    input  logic [ADDR_W-1:0]      WrAddr,
    input  logic [DATA_W-1:0]      WrData,
    input  logic                   ClearOvf,
    output logic                   TrkValid,
    input  logic                   TrkReady,
    output logic [ADDR_W-1:0]      TrkAddr,
    output logic [DATA_W-1:0]      TrkData,
    output logic [TS_W-1:0]        TrkTime,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Overflow,
    output logic [DROP_W-1:0]      DropCnt
);

    logic [TS_W-1:0]   r_ts;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    trk_entry_t        w_entry;
    trk_entry_t        w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push_req;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [DROP_W-1:0] w_drop_base;
    logic [DROP_W-1:0] w_drop_next;

    // Free-running capture timestamp; wraps silently
    always_ff @(posedge Clk) begin
        if (Reset) r_ts <= '0;
        else       r_ts <= r_ts + 1'b1;
    end

    assign w_entry.ts   = r_ts;
    assign w_entry.addr = WrAddr;
    assign w_entry.data = WrData;

    assign w_push_req = Enable && WrEn;
    assign w_pop      = !w_empty && TrkReady;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    trk_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (Count)
    );

    // A clear in the same cycle as a drop restarts the count at this drop
    assign w_drop_base = ClearOvf ? '0 : r_drop_cnt;
    assign w_drop_next = (w_drop_base == {DROP_W{1'b1}}) ? w_drop_base : w_drop_base + 1'b1;

    // Sticky overflow flag and saturating drop counter; a drop beats a clear
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= w_drop_next;
        end else if (ClearOvf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    // Head fields are forced to zero while empty so reset and idle states read clean
    assign TrkValid = !w_empty;
    assign TrkAddr  = TrkValid ? w_head.addr : '0;
    assign TrkData  = TrkValid ? w_head.data : '0;
    assign TrkTime  = TrkValid ? w_head.ts   : '0;
    assign Overflow = r_overflow;
    assign DropCnt  = r_drop_cnt;

endmodule

// File: tb/tb_dmem_wr_tracker.sv
// tb/tb_dmem_wr_tracker.sv - directed and scoreboard checks for dmem_wr_tracker
module tb_dmem_wr_tracker;
    import trk_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic        WrEn = 1'b0;
    logic [14:0] WrAddr = '0;
    logic [15:0] WrData = '0;
    logic        ClearOvf = 1'b0;
    logic        TrkValid;
    logic        TrkReady = 1'b0;
    logic [14:0] TrkAddr;
    logic [15:0] TrkData;
    logic [31:0] TrkTime;
    logic [4:0]  Count;
    logic        Overflow;
    logic [15:0] DropCnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_t [16];
    trk_entry_t q [$];
    int drops;

    dmem_wr_tracker #(
        .ADDR_W (15), .DATA_W (16), .DEPTH (16), .TS_W (32), .DROP_W (16)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Enable   (Enable),
        .WrEn     (WrEn),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .ClearOvf (ClearOvf),
        .TrkValid (TrkValid),
        .TrkReady (TrkReady),
        .TrkAddr  (TrkAddr),
        .TrkData  (TrkData),
        .TrkTime  (TrkTime),
        .Count    (Count),
        .Overflow (Overflow),
        .DropCnt  (DropCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the edge
    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Test 1: reset state, single write at cycle 10, empty-FIFO push with ready high
        do_reset();
        check_eq("rst_valid", 64'(TrkValid), 64'd0);
        check_eq("rst_count", 64'(Count), 64'd0);
        check_eq("rst_ovf",   64'(Overflow), 64'd0);
        check_eq("rst_drop",  64'(DropCnt), 64'd0);
        check_eq("rst_addr",  64'(TrkAddr), 64'd0);
        check_eq("rst_data",  64'(TrkData), 64'd0);
        check_eq("rst_time",  64'(TrkTime), 64'd0);
        Enable = 1'b1;
        TrkReady = 1'b1;
        repeat (10) tick();
        WrEn = 1'b1; WrAddr = 15'h0010; WrData = 16'h1234;
        tick();
        WrEn = 1'b0;
        check_eq("t1_valid", 64'(TrkValid), 64'd1);
        check_eq("t1_time",  64'(TrkTime), 64'd10);
        check_eq("t1_addr",  64'(TrkAddr), 64'h0010);
        check_eq("t1_data",  64'(TrkData), 64'h1234);
        check_eq("t1_count", 64'(Count), 64'd1);
        tick();
        check_eq("t1_popped_count", 64'(Count), 64'd0);
        check_eq("t1_popped_valid", 64'(TrkValid), 64'd0);

        // Test 2: fill to 16, one dropped write, in-order drain
        TrkReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            WrEn = 1'b1; WrAddr = 15'(15'h100 + i); WrData = 16'(i);
            exp_t[i] = cyc;
            tick();
        end
        check_eq("t2_full_count", 64'(Count), 64'd16);
        check_eq("t2_no_ovf", 64'(Overflow), 64'd0);
        WrData = 16'd16;
        tick();
        WrEn = 1'b0;
        check_eq("t2_drop_count", 64'(Count), 64'd16);
        check_eq("t2_ovf", 64'(Overflow), 64'd1);
        check_eq("t2_dropcnt", 64'(DropCnt), 64'd1);
        TrkReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t2_valid%0d", i), 64'(TrkValid), 64'd1);
            check_eq($sformatf("t2_data%0d", i), 64'(TrkData), 64'(i));
            check_eq($sformatf("t2_addr%0d", i), 64'(TrkAddr), 64'(15'h100 + i));
            check_eq($sformatf("t2_time%0d", i), 64'(TrkTime), 64'(exp_t[i]));
            tick();
        end
        TrkReady = 1'b0;
        check_eq("t2_empty", 64'(Count), 64'd0);
        ClearOvf = 1'b1;
        tick();
        ClearOvf = 1'b0;
        check_eq("t2_clr_ovf", 64'(Overflow), 64'd0);
        check_eq("t2_clr_drop", 64'(DropCnt), 64'd0);

        // Test 3: full with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            WrEn = 1'b1; WrAddr = 15'h0200; WrData = 16'(16'h200 + i);
            tick();
        end
        WrData = 16'h0055; TrkReady = 1'b1;
        tick();
        TrkReady = 1'b0;
        check_eq("t3_count", 64'(Count), 64'd16);
        check_eq("t3_ovf", 64'(Overflow), 64'd0);
        check_eq("t3_drop", 64'(DropCnt), 64'd0);
        check_eq("t3_head", 64'(TrkData), 64'h201);

        // Test 4: drops, saturating count, clear colliding with a drop
        WrData = 16'h0066;
        tick();
        check_eq("t4_drop1", 64'(DropCnt), 64'd1);
        tick();
        check_eq("t4_drop2", 64'(DropCnt), 64'd2);
        ClearOvf = 1'b1;
        tick();
        check_eq("t4_clr_drop_ovf", 64'(Overflow), 64'd1);
        check_eq("t4_clr_drop_cnt", 64'(DropCnt), 64'd1);
        WrEn = 1'b0;
        tick();
        ClearOvf = 1'b0;
        check_eq("t4_clr_ovf", 64'(Overflow), 64'd0);
        check_eq("t4_clr_cnt", 64'(DropCnt), 64'd0);
        Enable = 1'b0; WrEn = 1'b1;
        tick();
        WrEn = 1'b0; Enable = 1'b1;
        check_eq("t4_dis_drop", 64'(DropCnt), 64'd0);
        check_eq("t4_dis_count", 64'(Count), 64'd16);
        TrkReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t3_drain%0d", i), 64'(TrkData),
                     (i == 15) ? 64'h55 : 64'(16'h201 + i));
            tick();
        end
        TrkReady = 1'b0;
        check_eq("t3_drained", 64'(Count), 64'd0);

        // Test 5: reset mid-stream flushes and restarts the timestamp
        for (int i = 0; i < 5; i++) begin
            WrEn = 1'b1; WrData = 16'(16'h300 + i);
            tick();
        end
        WrEn = 1'b0;
        check_eq("t5_count5", 64'(Count), 64'd5);
        do_reset();
        check_eq("t5_valid", 64'(TrkValid), 64'd0);
        check_eq("t5_count", 64'(Count), 64'd0);
        WrEn = 1'b1; WrAddr = 15'h0abc; WrData = 16'h0077;
        tick();
        WrEn = 1'b0;
        check_eq("t5_valid_after", 64'(TrkValid), 64'd1);
        check_eq("t5_time0", 64'(TrkTime), 64'd0);
        check_eq("t5_data", 64'(TrkData), 64'h77);

        // Test 6: write-log scoreboard with irregular enable and back-pressure
        do_reset();
        drops = 0;
        q.delete();
        for (int n = 0; n < 300; n++) begin
            logic pop_m;
            logic full_m;
            trk_entry_t e;
            Enable   = ($urandom_range(0, 3) != 0);
            WrEn     = 1'($urandom_range(0, 1));
            TrkReady = ($urandom_range(0, 2) == 0);
            WrAddr   = 15'($urandom);
            WrData   = 16'($urandom);
            #1;
            check_eq("t6_valid", 64'(TrkValid), 64'(q.size() != 0));
            full_m = (q.size() == 16);
            pop_m  = (q.size() != 0) && TrkReady;
            if (pop_m) begin
                check_eq("t6_addr", 64'(TrkAddr), 64'(q[0].addr));
                check_eq("t6_data", 64'(TrkData), 64'(q[0].data));
                check_eq("t6_time", 64'(TrkTime), 64'(q[0].ts));
                void'(q.pop_front());
            end
            if (Enable && WrEn) begin
                if (!full_m || pop_m) begin
                    e.ts = 32'(cyc); e.addr = WrAddr; e.data = WrData;
                    q.push_back(e);
                end else begin
                    drops++;
                end
            end
            tick();
            check_eq("t6_count", 64'(Count), 64'(q.size()));
        end
        check_eq("t6_dropcnt", 64'(DropCnt), 64'(drops));
        check_eq("t6_ovf", 64'(Overflow), 64'(drops != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
